// File: rtl/seq_subt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_subt_pkg
//  Description : Shared types and default constants for the sequential
//                chunked subtractor (FSM state encoding, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_subt_pkg;

  // Default operand width and bits processed per clock
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Controller states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : seq_subt_pkg
`default_nettype wire

// File: rtl/subt_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : subt_chunk
//  Description : Combinational ripple-borrow subtractor slice,
//                d = a - b - bin over CHUNK bits, with borrow-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module subt_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  // Borrow chain: w_brw[i] is the borrow into bit i
  logic [CHUNK:0] w_brw;

  assign w_brw[0] = bin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    // Full-subtractor cell: borrow when a < b + borrow-in at this bit
    assign d[i]         = a[i] ^ b[i] ^ w_brw[i];
    assign w_brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_brw[i]);
  end

  assign bout = w_brw[CHUNK];

endmodule : subt_chunk
`default_nettype wire

// File: rtl/seq_subt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_subt
//  Description : Multi-cycle subtractor d = a - b - bin, CHUNK bits per clock
//                with a registered borrow between chunks. start/busy/done
//                handshake; registered d, bout, ovf and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_subt
  import seq_subt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_asgn;
  logic             r_bsgn;
  logic             r_brw;
  logic [IDXW-1:0]  r_idx;
  logic             w_accept;
  logic             w_last;
  logic             w_run;
  logic [CHUNK-1:0] w_cd;
  logic             w_cb;
  logic [WIDTH-1:0] w_dnew;

  // Operands are shifted down each cycle, so the active chunk is always the
  // low CHUNK bits of the latched operands.
  subt_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .bin  (r_brw),
    .d    (w_cd),
    .bout (w_cb)
  );

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_idx == C_LAST);

  // The difference shadow fills from the top as chunks complete; the full
  // word is only copied to d on the final chunk.
  if (NCHUNK > 1) begin : g_multi
    logic [WIDTH-CHUNK-1:0] r_dsh;

    assign w_dnew = {w_cd, r_dsh};

    // Shadow register collects completed chunks, never visible on d
    always_ff @(posedge clk) begin
      if (rst) begin
        r_dsh <= '0;
      end else if (w_run) begin
        r_dsh <= w_dnew[WIDTH-1:CHUNK];
      end
    end
  end else begin : g_single
    assign w_dnew = w_cd;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, chunk sequencing, borrow register and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_asgn <= 1'b0;
      r_bsgn <= 1'b0;
      r_brw  <= 1'b0;
      r_idx  <= '0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_asgn <= a[WIDTH-1];
      r_bsgn <= b[WIDTH-1];
      r_brw  <= bin;
      r_idx  <= '0;
    end else if (w_run) begin
      r_a   <= r_a >> CHUNK;
      r_b   <= r_b >> CHUNK;
      r_brw <= w_cb;
      if (w_last) begin
        r_idx <= '0;
        d     <= w_dnew;
        bout  <= w_cb;
        ovf   <= (r_asgn != r_bsgn) && (w_dnew[WIDTH-1] != r_asgn);
        zero  <= (w_dnew == '0);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

endmodule : seq_subt
`default_nettype wire

// File: tb/tb_seq_subt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_subt
//  Description : Self-checking bench for seq_subt. A transaction-level model
//                tracks the 16/4 instance every cycle; directed vectors carry
//                literal expectations; a 16/16 instance runs a corner sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_subt;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  logic          clk = 1'b0;
  logic          rst;
  // 16/4 instance
  logic          start, bin;
  logic [W-1:0]  a, b;
  logic          busy, done, bout, ovf, zero;
  logic [W-1:0]  d;
  // 16/16 instance
  logic          start1, bin1;
  logic [W-1:0]  a1, b1;
  logic          busy1, done1, bout1, ovf1, zero1;
  logic [W-1:0]  d1;

  int   n_vec = 0;
  int   n_err = 0;
  logic chk_on = 1'b0;

  seq_subt #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf), .zero(zero)
  );

  seq_subt #(.WIDTH(W), .CHUNK(W)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1), .zero(zero1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic: returns {bout, ovf, zero, d}
  function automatic logic [W+2:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic bi);
    logic [W:0] u;
    int         s;
    u = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    return {u[W], (s > 32767) || (s < -32768), (u[W-1:0] == '0), u[W-1:0]};
  endfunction

  // Transaction model of the 16/4 instance: an accepted request completes
  // NC clocks later; requests are taken only when no operation is in flight.
  int          m_rem  = 0;
  logic        m_done = 1'b0;
  logic [W-1:0] m_a, m_b;
  logic        m_bin;
  logic [W-1:0] m_d    = '0;
  logic        m_bout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;

  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      m_rem = 0; m_done = 1'b0; m_d = '0;
      m_bout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
    end else begin
      acc    = (m_rem == 0) && start;
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1'b1;
          {m_bout, m_ovf, m_zero, m_d} = golden(m_a, m_b, m_bin);
        end
      end
      if (acc) begin
        m_a = a; m_b = b; m_bin = bin; m_rem = NC;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      chk("d",    d,    m_d);
      chk("bout", bout, m_bout);
      chk("ovf",  ovf,  m_ovf);
      chk("zero", zero, m_zero);
    end
  end

  // Wait for done on the 16/4 instance; lat counts edges from the accept edge
  task automatic wait_done(input bit drop, output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      if (drop) start = 1'b0;
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 20);
    chk("done_seen", done, 1);
  endtask

  task automatic op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic bi, input logic [W-1:0] ed, input logic eb,
                    input logic eo, input logic ez);
    int lat, nb;
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    wait_done(1'b1, lat, nb);
    chk({nm, "_lat"},  lat - 1, NC);
    chk({nm, "_busy"}, nb, NC);
    chk({nm, "_d"},    d, ed);
    chk({nm, "_bout"}, bout, eb);
    chk({nm, "_ovf"},  ovf, eo);
    chk({nm, "_zero"}, zero, ez);
  endtask

  initial begin
    logic [3:0]   vals [5];
    logic [W+2:0] g;
    int lat, nb, t1;
    vals = '{4'h0, 4'h1, 4'h7, 4'h8, 4'hF};
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_d",    d, 0);
    chk("rst_flags", {bout, ovf, zero}, 0);
    chk_on = 1'b1;
    rst    = 1'b0;

    op("basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    op("ripple",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    op("zero",    16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

    // start re-pulsed during RUN with new operands is ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1'b1, lat, nb);
    chk("ign_lat", lat + 2, NC);
    chk("ign_d", d, 16'h1000);

    // reset in the middle of RUN aborts with everything cleared
    @(negedge clk);
    a = 16'h0000; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_d", d, 0);
    chk("abort_flags", {bout, ovf, zero}, 0);
    nb = 0;
    repeat (NC + 2) begin
      @(negedge clk);
      if (done) nb++;
    end
    chk("abort_nodone", nb, 0);

    // start held high: DONE hands straight to the next operation
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
    wait_done(1'b0, lat, nb);
    chk("b2b_lat1", lat - 1, NC);
    chk("b2b_d1", d, 16'h7FFF);
    chk("b2b_ovf1", ovf, 1);
    a = 16'h7FFF; b = 16'hFFFF;
    t1 = 0;
    @(negedge clk); t1++;
    chk("b2b_nogap", busy, 1);
    wait_done(1'b0, lat, nb);
    start = 1'b0;
    chk("b2b_gap", t1 + lat, NC + 1);
    chk("b2b_d2", d, 16'h8000);
    chk("b2b_flags2", {bout, ovf, zero}, 3'b110);

    // single-chunk instance: corner sweep
    foreach (vals[i]) foreach (vals[j]) for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a1 = {12'h000, vals[i]}; b1 = {12'h000, vals[j]}; bin1 = k[0]; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      chk("s16_busy", {busy1, done1}, 2'b10);
      @(negedge clk);
      g = golden(a1, b1, bin1);
      chk("s16_done", done1, 1);
      chk("s16_res", {bout1, ovf1, zero1, d1}, g);
    end
    @(negedge clk);
    a1 = 16'h0008; b1 = 16'h000F; bin1 = 1'b1; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk);
    chk("s16_pin_d", d1, 16'hFFF8);
    chk("s16_pin_flags", {done1, bout1, ovf1, zero1}, 4'b1100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_subt
`default_nettype wire
